// File: rtl/ram4k_rr_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter:
// geometry defaults, requester id and read-return tag.
package ram_arb_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 24;

   typedef enum logic {
      REQ0 = 1'b0,
      REQ1 = 1'b1
   } req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } tag_t;

endpackage

// File: rtl/ram4k_rr_arbiter_if.sv
// Requester handshakes and RAM pins for the arbiter.
// master = requesters plus RAM, slave = arbiter.
interface ram4k_rr_arbiter_if
   import ram_arb_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] din0, din1;
   logic          gnt0, gnt1;
   logic          rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] ram_addr;
   logic          ram_we, ram_re;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport master (
      output req0, req1, we0, we1,
      output addr0, addr1, din0, din1,
      output ram_dout,
      input  gnt0, gnt1, rvalid0, rvalid1,
      input  rdata0, rdata1,
      input  ram_addr, ram_we, ram_re, ram_din
   );

   modport slave (
      input  req0, req1, we0, we1,
      input  addr0, addr1, din0, din1,
      input  ram_dout,
      output gnt0, gnt1, rvalid0, rvalid1,
      output rdata0, rdata1,
      output ram_addr, ram_we, ram_re, ram_din
   );
endinterface

// File: rtl/ram4k_rr_arbiter_rr_arb2.sv
// Two-way round-robin picker; owns the last-winner flag.
// Grants are combinational and forced low while en is low.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (1'b1)
            (req == 2'b11): gnt = last ? 2'b01 : 2'b10;
            (req == 2'b01): gnt = 2'b01;
            (req == 2'b10): gnt = 2'b10;
            default:        gnt = 2'b00;
         endcase
      end
   end

   // last = 1 after reset so requester 0 takes the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= 1'b1;
      else if (|gnt)
         last <= gnt[1];
   end

endmodule

// File: rtl/ram4k_rr_arbiter.sv
// Round-robin front end for the 4096 x 24 single-port RAM:
// command register, read tag pipeline and return demux.
module ram4k_rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input logic               clk,
   input logic               rst,
   ram4k_rr_arbiter_if.slave bus
);

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              acc;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_din;
   tag_t              tags [RD_LAT+1];
   tag_t              t_out;

   assign req = {bus.req1, bus.req0};

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .en  (~rst),
      .req (req),
      .gnt (gnt)
   );

   assign bus.gnt0 = gnt[0];
   assign bus.gnt1 = gnt[1];
   assign acc      = |gnt;

   always_comb begin
      sel_we   = bus.we0;
      sel_addr = bus.addr0;
      sel_din  = bus.din0;
      if (gnt[1]) begin
         sel_we   = bus.we1;
         sel_addr = bus.addr1;
         sel_din  = bus.din1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ram_addr <= '0;
         bus.ram_din  <= '0;
         bus.ram_we   <= 1'b0;
         bus.ram_re   <= 1'b0;
      end else if (acc) begin
         bus.ram_addr <= sel_addr;
         bus.ram_din  <= sel_din;
         bus.ram_we   <= sel_we;
         bus.ram_re   <= ~sel_we;
      end else begin
         bus.ram_we   <= 1'b0;
         bus.ram_re   <= 1'b0;
      end
   end

   // stage k holds a tag in cycle grant+1+k; exit aligns with Dout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= RD_LAT; i++)
            tags[i] <= '0;
      end else begin
         tags[0] <= '{valid: acc & ~sel_we,
                      id:    req_id_t'(gnt[1])};
         for (int i = 1; i <= RD_LAT; i++)
            tags[i] <= tags[i-1];
      end
   end

   assign t_out       = tags[RD_LAT];
   assign bus.rvalid0 = t_out.valid & (t_out.id == REQ0);
   assign bus.rvalid1 = t_out.valid & (t_out.id == REQ1);
   assign bus.rdata0  = bus.ram_dout;
   assign bus.rdata1  = bus.ram_dout;

endmodule

// File: tb/tb_ram4k_rr_arbiter.sv
// Directed bench for ram4k_rr_arbiter with a behavioural
// synchronous RAM; inputs change and outputs are checked on negedge.
module tb_ram4k_rr_arbiter;
   import ram_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   ram4k_rr_arbiter_if bus ();

   ram4k_rr_arbiter #(.RD_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] mem [4096];
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
      if (bus.ram_re) bus.ram_dout <= mem[bus.ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.din0 = 0; bus.din1 = 0;

      // reset: grant held off even with a request pending
      @(negedge clk); bus.req0 = 1; #1;
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_we", bus.ram_we, 0);
      chk("rst_re", bus.ram_re, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_din", bus.ram_din, 0);
      chk("rst_rv0", bus.rvalid0, 0);
      chk("rst_rv1", bus.rvalid1, 0);
      bus.req0 = 0;
      @(negedge clk); rst = 0;

      // single write 545 <- 64
      @(negedge clk);
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 545; bus.din0 = 64; #1;
      chk("wr_gnt0", bus.gnt0, 1);
      chk("wr_gnt1", bus.gnt1, 0);
      @(negedge clk); bus.req0 = 0; #1;
      chk("wr_ram_we", bus.ram_we, 1);
      chk("wr_ram_re", bus.ram_re, 0);
      chk("wr_ram_addr", bus.ram_addr, 545);
      chk("wr_ram_din", bus.ram_din, 64);

      // read back 545 by requester 0
      @(negedge clk); bus.req0 = 1; bus.we0 = 0; #1;
      chk("rd_gnt0", bus.gnt0, 1);
      @(negedge clk); bus.req0 = 0; #1;
      chk("rd_ram_re", bus.ram_re, 1);
      chk("rd_ram_we", bus.ram_we, 0);
      chk("rd_rv0_early", bus.rvalid0, 0);
      @(negedge clk); #1;
      chk("rd_rv0", bus.rvalid0, 1);
      chk("rd_rdata0", bus.rdata0, 64);
      chk("rd_rv1", bus.rvalid1, 0);
      chk("idle_we", bus.ram_we, 0);
      chk("idle_re", bus.ram_re, 0);
      chk("idle_addr", bus.ram_addr, 545);
      @(negedge clk); #1;
      chk("rd_rv0_pulse", bus.rvalid0, 0);

      // requester 1 reads 545 alone
      @(negedge clk);
      bus.req1 = 1; bus.we1 = 0; bus.addr1 = 545; #1;
      chk("r1_gnt1", bus.gnt1, 1);
      chk("r1_gnt0", bus.gnt0, 0);
      @(negedge clk); bus.req1 = 0;
      @(negedge clk); #1;
      chk("r1_rv1", bus.rvalid1, 1);
      chk("r1_rdata1", bus.rdata1, 64);
      chk("r1_rv0", bus.rvalid0, 0);

      // same-address write race on 721
      @(negedge clk);
      bus.req0 = 1; bus.we0 = 1; bus.addr0 = 721; bus.din0 = 78;
      bus.req1 = 1; bus.we1 = 1; bus.addr1 = 721; bus.din1 = 99; #1;
      chk("race_gnt0", bus.gnt0, 1);
      chk("race_gnt1_a", bus.gnt1, 0);
      @(negedge clk); bus.req0 = 0; #1;
      chk("race_gnt1", bus.gnt1, 1);
      chk("race_din_a", bus.ram_din, 78);
      chk("race_addr", bus.ram_addr, 721);
      @(negedge clk); bus.req1 = 0; #1;
      chk("race_din_b", bus.ram_din, 99);
      chk("race_we_b", bus.ram_we, 1);

      // contention: reads 721 (r0) and 545 (r1) for 6 cycles
      bus.we0 = 0; bus.addr0 = 721; bus.we1 = 0; bus.addr1 = 545;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.req0 = (k < 6); bus.req1 = (k < 6); #1;
         chk($sformatf("ct_gnt0_%0d", k), bus.gnt0,
             (k < 6) && (k % 2 == 0));
         chk($sformatf("ct_gnt1_%0d", k), bus.gnt1,
             (k < 6) && (k % 2 == 1));
         if (k >= 2) begin
            chk($sformatf("ct_rv0_%0d", k), bus.rvalid0, k % 2 == 0);
            chk($sformatf("ct_rv1_%0d", k), bus.rvalid1, k % 2 == 1);
            chk($sformatf("ct_rdata_%0d", k), bus.rdata0,
                (k % 2 == 0) ? 99 : 64);
         end
      end

      // reset in the cycle after a read grant
      @(negedge clk);
      bus.req0 = 1; bus.req1 = 0; #1;
      chk("mr_gnt0", bus.gnt0, 1);
      @(negedge clk); bus.req0 = 0; rst = 1; #1;
      chk("mr_re", bus.ram_re, 0);
      chk("mr_rv0_a", bus.rvalid0, 0);
      @(negedge clk); bus.req0 = 1; bus.req1 = 1; #1;
      chk("mr_rv0_b", bus.rvalid0, 0);
      chk("mr_gnt_hold", {bus.gnt1, bus.gnt0}, 0);
      @(negedge clk); rst = 0; #1;
      chk("mr_rv0_c", bus.rvalid0, 0);
      chk("mr_tie_gnt0", bus.gnt0, 1);
      chk("mr_tie_gnt1", bus.gnt1, 0);
      @(negedge clk); bus.req0 = 0; bus.req1 = 0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
